// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversampled SCLK/CS_N/MOSI, byte deserialiser and
// one-deep transmit buffer feeding the MISO shifter.
module spi_responder #(
    parameter logic [7:0] FILL_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCLK,
    input  logic       CS_N,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_ovf,
    output logic       tx_undf,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIME_MAX = PW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_last_q;
    logic                   cs_last_q;
    logic [PW-1:0]          prime_q;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic edges_ok;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    state_t     state_q, state_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       tx_full_q, tx_full_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [6:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       load_done_q, load_done_d;
    logic       miso_q, miso_d;
    logic       miso_oe_q, miso_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_ovf_q, tx_ovf_d;
    logic       tx_undf_q, tx_undf_d;
    logic       load_c;
    logic       consumed_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '1;
            sclk_last_q <= 1'b1;
            cs_last_q   <= 1'b1;
            prime_q     <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sclk_last_q <= sclk_s;
            cs_last_q   <= cs_s;
            if (prime_q != PRIME_MAX) begin
                prime_q <= prime_q + 1'b1;
            end
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Edges stay masked until the chain holds real pin samples, so a CS_N
    // already low at reset release is not mistaken for a fresh fall.
    assign edges_ok  = (prime_q == PRIME_MAX);
    assign sclk_rise = edges_ok & sclk_s & ~sclk_last_q;
    assign sclk_fall = edges_ok & ~sclk_s & sclk_last_q;
    assign cs_rise   = edges_ok & cs_s & ~cs_last_q;
    assign cs_fall   = edges_ok & ~cs_s & cs_last_q;

    always_comb begin
        state_d     = state_q;
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        load_done_d = load_done_q;
        miso_oe_d   = miso_oe_q;
        rx_valid_d  = 1'b0;
        tx_ovf_d    = 1'b0;
        tx_undf_d   = 1'b0;
        load_c      = 1'b0;
        consumed_c  = 1'b0;
        miso_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                miso_oe_d = 1'b0;
                if (cs_fall) begin
                    state_d   = SHIFT;
                    load_c    = 1'b1;
                    bit_cnt_d = 3'd0;
                    miso_oe_d = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    miso_oe_d   = 1'b0;
                    bit_cnt_d   = 3'd0;
                    load_done_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_sh_d     = {rx_sh_q[5:0], mosi_s};
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    load_done_d = 1'b0;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {rx_sh_q, mosi_s};
                        rx_valid_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end else if (!load_done_q) begin
                        load_c = 1'b1;
                    end
                end
            end
        endcase

        if (load_c) begin
            tx_sh_d     = tx_full_q ? tx_buf_q : FILL_BYTE;
            tx_undf_d   = ~tx_full_q;
            consumed_c  = tx_full_q;
            load_done_d = 1'b1;
        end

        // A write landing on the consuming cycle refills the freed slot.
        if (tx_wr) begin
            if (tx_full_q && !consumed_c) begin
                tx_ovf_d = 1'b1;
            end else begin
                tx_buf_d  = tx_data;
                tx_full_d = 1'b1;
            end
        end else if (consumed_c) begin
            tx_full_d = 1'b0;
        end

        if (state_d == SHIFT) begin
            miso_d = tx_sh_d[7];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tx_buf_q    <= 8'h00;
            tx_full_q   <= 1'b0;
            tx_sh_q     <= 8'h00;
            rx_sh_q     <= 7'h00;
            rx_data_q   <= 8'h00;
            bit_cnt_q   <= 3'd0;
            load_done_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_ovf_q    <= 1'b0;
            tx_undf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            load_done_q <= load_done_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            rx_valid_q  <= rx_valid_d;
            tx_ovf_q    <= tx_ovf_d;
            tx_undf_q   <= tx_undf_d;
        end
    end

    assign MISO     = miso_q;
    assign MISO_OE  = miso_oe_q;
    assign tx_full  = tx_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ovf   = tx_ovf_q;
    assign tx_undf  = tx_undf_q;
    assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: bit-banged SPI master, queue-based byte-level
// model of the transmit buffer and a scoreboard fed by output monitors.
module tb_spi_responder;

    localparam int HALF = 6;
    localparam logic [7:0] FILL = 8'hFF;

    logic       clk = 1'b0;
    logic       reset;
    logic       SCLK;
    logic       CS_N;
    logic       MOSI;
    logic       MISO;
    logic       MISO_OE;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ovf;
    logic       tx_undf;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tx_q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];
    bit         exp_undf[$];
    bit         exp_ovf[$];
    logic [7:0] mosi_buf[$];
    logic [7:0] last_rx;

    bit         mon_en = 1'b0;
    int         mon_n = 0;
    logic [7:0] mon_sh = 8'h00;

    spi_responder dut (
        .clk     (clk),
        .reset   (reset),
        .SCLK    (SCLK),
        .CS_N    (CS_N),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .MISO_OE (MISO_OE),
        .tx_data (tx_data),
        .tx_wr   (tx_wr),
        .tx_full (tx_full),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_ovf  (tx_ovf),
        .tx_undf (tx_undf),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard for the pulse outputs.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (exp_rx.size() == 0) begin
                chk("rx_valid_unexpected", 1, 0);
            end else begin
                chk("rx_data", rx_data, exp_rx.pop_front());
            end
        end
        if (tx_undf === 1'b1) begin
            if (exp_undf.size() == 0) begin
                chk("tx_undf_unexpected", 1, 0);
            end else begin
                chk("tx_undf", 1, 32'(exp_undf.pop_front()));
            end
        end
        if (tx_ovf === 1'b1) begin
            if (exp_ovf.size() == 0) begin
                chk("tx_ovf_unexpected", 1, 0);
            end else begin
                chk("tx_ovf", 1, 32'(exp_ovf.pop_front()));
            end
        end
    end

    // MISO byte collector, sampled where the master samples (SCLK rise).
    initial begin
        forever begin
            @(posedge SCLK);
            if (mon_en) begin
                mon_sh = {mon_sh[6:0], MISO};
                mon_n++;
                if (mon_n == 8) begin
                    mon_n = 0;
                    if (exp_miso.size() == 0) begin
                        chk("miso_unexpected", 32'(mon_sh), 32'hFFFF);
                    end else begin
                        chk("miso_byte", 32'(mon_sh), 32'(exp_miso.pop_front()));
                    end
                end
            end
        end
    end

    task automatic host_wr(input logic [7:0] b);
        tx_data = b;
        tx_wr   = 1'b1;
        tick(1);
        tx_wr   = 1'b0;
        if (tx_q.size() > 0) exp_ovf.push_back(1'b1);
        else tx_q.push_back(b);
        chk("tx_full_wr", tx_full, 32'(tx_q.size() > 0));
    endtask

    function automatic logic mosi_bit(input int i);
        logic [7:0] cur;
        cur = mosi_buf[i / 8] << (i % 8);
        return cur[7];
    endfunction

    task automatic byte_load(input bit keep);
        logic [7:0] b;
        if (tx_q.size() > 0) begin
            b = tx_q.pop_front();
        end else begin
            b = FILL;
            exp_undf.push_back(1'b1);
        end
        if (keep) exp_miso.push_back(b);
    endtask

    // nb whole bytes then p extra bits; last SCLK fall coincides with CS_N rise.
    task automatic run_frame(input int nb, input int p, input bit inj,
                             input logic [7:0] inj_b);
        int nbits;
        int loads;
        nbits = nb * 8 + p;
        loads = nb + ((p > 0) ? 1 : 0);
        for (int k = 0; k < loads; k++) begin
            byte_load(k < nb);
            if (k == 0 && inj) tx_q.push_back(inj_b);
        end
        for (int k = 0; k < nb; k++) begin
            exp_rx.push_back(mosi_buf[k]);
            last_rx = mosi_buf[k];
        end
        mon_n  = 0;
        mon_en = 1'b1;
        CS_N   = 1'b0;
        MOSI   = mosi_bit(0);
        if (inj) begin
            tick(2);
            tx_data = inj_b;
            tx_wr   = 1'b1;
            tick(1);
            tx_wr   = 1'b0;
            chk("tx_full_inject", tx_full, 1);
            tick(HALF - 3);
        end else begin
            tick(HALF);
        end
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b1;
            tick(HALF);
            SCLK = 1'b0;
            if (i == nbits - 1) CS_N = 1'b1;
            else MOSI = mosi_bit(i + 1);
            tick(HALF);
        end
        mon_en = 1'b0;
        tick(4);
        chk("busy_after", busy, 0);
        chk("oe_after", MISO_OE, 0);
        chk("rx_hold", rx_data, last_rx);
    endtask

    task automatic set_mosi(input int n);
        mosi_buf = {};
        for (int k = 0; k < n; k++) mosi_buf.push_back(8'($urandom));
    endtask

    initial begin
        reset   = 1'b1;
        SCLK    = 1'b0;
        CS_N    = 1'b1;
        MOSI    = 1'b0;
        tx_data = 8'h00;
        tx_wr   = 1'b0;
        last_rx = 8'h00;
        tick(4);
        reset = 1'b0;
        tick(1);
        chk("rst_miso", MISO, 0);
        chk("rst_oe", MISO_OE, 0);
        chk("rst_full", tx_full, 0);
        chk("rst_rx", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {rx_valid, tx_ovf, tx_undf}, 0);
        tick(6);

        host_wr(8'hA5);
        mosi_buf = {8'h3C};
        run_frame(1, 0, 1'b0, 8'h00);
        chk("rx_3c", rx_data, 8'h3C);

        mosi_buf = {8'h01, 8'h02, 8'h00};
        run_frame(2, 0, 1'b0, 8'h00);

        host_wr(8'h11);
        host_wr(8'h22);
        set_mosi(2);
        run_frame(1, 0, 1'b0, 8'h00);

        set_mosi(2);
        run_frame(0, 5, 1'b0, 8'h00);

        host_wr(8'h11);
        set_mosi(3);
        run_frame(2, 0, 1'b1, 8'h5A);
        chk("tx_full_drain", tx_full, 0);

        // Reset at bit 3 with CS_N held low.
        byte_load(1'b0);
        mon_en = 1'b0;
        CS_N   = 1'b0;
        tick(HALF);
        for (int i = 0; i < 3; i++) begin
            MOSI = 1'($urandom);
            SCLK = 1'b1;
            tick(HALF);
            SCLK = 1'b0;
            tick(HALF);
        end
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tx_q.delete();
        last_rx = 8'h00;
        tick(1);
        chk("mrst_busy", busy, 0);
        chk("mrst_oe", MISO_OE, 0);
        chk("mrst_full", tx_full, 0);
        chk("mrst_rx", rx_data, 0);
        for (int i = 0; i < 10; i++) begin
            MOSI = 1'($urandom);
            SCLK = 1'b1;
            tick(HALF);
            SCLK = 1'b0;
            tick(HALF);
        end
        chk("mrst_idle", busy, 0);
        CS_N = 1'b1;
        tick(HALF);

        for (int f = 0; f < 14; f++) begin
            int nw;
            int nb;
            int p;
            bit inj;
            nw  = $urandom_range(0, 2);
            nb  = $urandom_range(1, 3);
            p   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            inj = ($urandom_range(0, 3) == 0);
            for (int w = 0; w < nw; w++) host_wr(8'($urandom));
            set_mosi(4);
            run_frame(nb, p, inj, 8'($urandom));
            chk("tx_full_frame", tx_full, 32'(tx_q.size() > 0));
            tick(3);
        end

        tick(4);
        chk("left_rx", exp_rx.size(), 0);
        chk("left_miso", exp_miso.size(), 0);
        chk("left_undf", exp_undf.size(), 0);
        chk("left_ovf", exp_ovf.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
